// File: rtl/code_entry_unit.sv
// Secret-code entry controller: collects DIGITS symbols from the owning player's
// switches, supports delete and optional duplicate rejection, then hands the code off.
module code_entry_unit #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 3,
  parameter int ALLOW_DUP = 1,
  localparam int CW       = $clog2(DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      code_maker,
  input  logic                      player_sel,
  input  logic                      enter_a,
  input  logic                      enter_b,
  input  logic                      del_a,
  input  logic                      del_b,
  input  logic [DIGIT_W-1:0]        sw,
  input  logic                      abort,
  input  logic                      code_ready,
  output logic                      active_p,
  output logic                      entering,
  output logic [CW-1:0]             count,
  output logic [DIGITS*DIGIT_W-1:0] code,
  output logic                      code_valid,
  output logic                      reject
);

  // state   | meaning
  // S_IDLE  | waiting for code_maker; last code stays visible
  // S_ENTRY | owner is keying digits
  // S_HOLD  | full code offered downstream, frozen until code_ready or abort
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int CODE_W = DIGITS * DIGIT_W;

  state_t              state, state_nxt;
  logic [CODE_W-1:0]   code_nxt;
  logic [CW-1:0]       count_nxt;
  logic                active_nxt;
  logic                reject_nxt;
  logic                own_enter;
  logic                own_del;
  logic                dup_hit;

  assign own_enter = active_p ? enter_b : enter_a;
  assign own_del   = active_p ? del_b   : del_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      code     <= '0;
      count    <= '0;
      active_p <= 1'b0;
      reject   <= 1'b0;
    end else begin
      state    <= state_nxt;
      code     <= code_nxt;
      count    <= count_nxt;
      active_p <= active_nxt;
      reject   <= reject_nxt;
    end
  end

  // Only the occupied low slots take part in the duplicate search.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((CW'(i) < count) && (code[i*DIGIT_W +: DIGIT_W] == sw)) dup_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    code_nxt   = code;
    count_nxt  = count;
    active_nxt = active_p;
    reject_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (code_maker) begin
          state_nxt  = S_ENTRY;
          active_nxt = player_sel;
          code_nxt   = '0;
          count_nxt  = '0;
        end
      end
      S_ENTRY: begin
        if (abort) begin
          state_nxt = S_IDLE;
          code_nxt  = '0;
          count_nxt = '0;
        end else if (own_del) begin
          if (count != '0) begin
            code_nxt  = code >> DIGIT_W;
            count_nxt = count - CW'(1);
          end
        end else if (own_enter) begin
          if ((ALLOW_DUP == 0) && dup_hit) begin
            reject_nxt = 1'b1;
          end else begin
            code_nxt  = {code[CODE_W-DIGIT_W-1:0], sw};
            count_nxt = count + CW'(1);
            if (count_nxt == CW'(DIGITS)) state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A completed handshake outranks abort so the accepted code survives.
        if (code_ready) begin
          state_nxt = S_IDLE;
        end else if (abort) begin
          state_nxt = S_IDLE;
          code_nxt  = '0;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        code_nxt   = '0;
        count_nxt  = '0;
        active_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    entering   = (state == S_ENTRY);
    code_valid = (state == S_HOLD);
  end

endmodule

// File: tb/tb_code_entry_unit.sv
// Three code_entry_unit variants on shared stimulus, checked against a digit-list
// model, a directed vector table, hand-written corner sequences and random traffic.
module tb_code_entry_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_maker = 0, player_sel = 0, enter_a = 0, enter_b = 0;
  logic       del_a = 0, del_b = 0, abort = 0, code_ready = 0;
  logic [3:0] sw_w = '0;

  logic        act_a, ent_a, val_a, rej_a;
  logic [2:0]  cnt_a;
  logic [11:0] code_a;
  logic        act_d, ent_d, val_d, rej_d;
  logic [2:0]  cnt_d;
  logic [11:0] code_d;
  logic        act_w, ent_w, val_w, rej_w;
  logic [2:0]  cnt_w;
  logic [23:0] code_w;

  always #5 clk = ~clk;

  code_entry_unit #(.DIGITS(4), .DIGIT_W(3), .ALLOW_DUP(1)) u_a (
    .clk(clk), .reset(reset), .code_maker(code_maker), .player_sel(player_sel),
    .enter_a(enter_a), .enter_b(enter_b), .del_a(del_a), .del_b(del_b), .sw(sw_w[2:0]),
    .abort(abort), .code_ready(code_ready), .active_p(act_a), .entering(ent_a),
    .count(cnt_a), .code(code_a), .code_valid(val_a), .reject(rej_a));

  code_entry_unit #(.DIGITS(4), .DIGIT_W(3), .ALLOW_DUP(0)) u_d (
    .clk(clk), .reset(reset), .code_maker(code_maker), .player_sel(player_sel),
    .enter_a(enter_a), .enter_b(enter_b), .del_a(del_a), .del_b(del_b), .sw(sw_w[2:0]),
    .abort(abort), .code_ready(code_ready), .active_p(act_d), .entering(ent_d),
    .count(cnt_d), .code(code_d), .code_valid(val_d), .reject(rej_d));

  code_entry_unit #(.DIGITS(6), .DIGIT_W(4), .ALLOW_DUP(1)) u_w (
    .clk(clk), .reset(reset), .code_maker(code_maker), .player_sel(player_sel),
    .enter_a(enter_a), .enter_b(enter_b), .del_a(del_a), .del_b(del_b), .sw(sw_w),
    .abort(abort), .code_ready(code_ready), .active_p(act_w), .entering(ent_w),
    .count(cnt_w), .code(code_w), .code_valid(val_w), .reject(rej_w));

  logic [23:0] dut_code [3];
  logic [2:0]  dut_cnt  [3];
  logic [2:0]  dut_act, dut_ent, dut_val, dut_rej;
  assign dut_code[0] = {12'b0, code_a};
  assign dut_code[1] = {12'b0, code_d};
  assign dut_code[2] = code_w;
  assign dut_cnt[0]  = cnt_a;
  assign dut_cnt[1]  = cnt_d;
  assign dut_cnt[2]  = cnt_w;
  assign dut_act = {act_w, act_d, act_a};
  assign dut_ent = {ent_w, ent_d, ent_a};
  assign dut_val = {val_w, val_d, val_a};
  assign dut_rej = {rej_w, rej_d, rej_a};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance keeps an ordered list of entered digits and a phase
  // (0 idle, 1 entering, 2 offering); the code is the list packed first-digit-high.
  int dd [3] = '{4, 4, 6};
  int ww [3] = '{3, 3, 4};
  int dup_ok [3] = '{1, 0, 1};
  int phase [3];
  int len [3];
  int own [3];
  int rej [3];
  int dig [3][8];

  function automatic logic [23:0] packed_code(input int k);
    logic [23:0] c = '0;
    for (int i = 0; i < len[k]; i++) c = (c << ww[k]) | 24'(dig[k][i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      phase[k] = 0; len[k] = 0; own[k] = 0; rej[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int s;
      bit en, dl, hit;
      rej[k] = 0;
      s  = int'(sw_w) & ((1 << ww[k]) - 1);
      en = own[k] ? enter_b : enter_a;
      dl = own[k] ? del_b : del_a;
      if (phase[k] == 0) begin
        if (code_maker) begin
          own[k] = player_sel; len[k] = 0; phase[k] = 1;
        end
      end else if (phase[k] == 1) begin
        if (abort) begin
          phase[k] = 0; len[k] = 0;
        end else if (dl) begin
          if (len[k] > 0) len[k]--;
        end else if (en) begin
          hit = 0;
          for (int i = 0; i < len[k]; i++) if (dig[k][i] == s) hit = 1;
          if (dup_ok[k] == 0 && hit) rej[k] = 1;
          else begin
            dig[k][len[k]] = s;
            len[k]++;
            if (len[k] == dd[k]) phase[k] = 2;
          end
        end
      end else begin
        if (code_ready) phase[k] = 0;
        else if (abort) begin
          phase[k] = 0; len[k] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("m%0d_count", k), 32'(dut_cnt[k]), 32'(len[k]));
      check($sformatf("m%0d_code", k), 32'(dut_code[k]), 32'(packed_code(k)));
      check($sformatf("m%0d_entering", k), 32'(dut_ent[k]), 32'(phase[k] == 1));
      check($sformatf("m%0d_valid", k), 32'(dut_val[k]), 32'(phase[k] == 2));
      check($sformatf("m%0d_active", k), 32'(dut_act[k]), 32'(own[k]));
      check($sformatf("m%0d_reject", k), 32'(dut_rej[k]), 32'(rej[k]));
    end
  endtask

  task automatic clear_inputs();
    code_maker = 0; player_sel = 0; enter_a = 0; enter_b = 0;
    del_a = 0; del_b = 0; abort = 0; code_ready = 0; sw_w = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_count", k), 32'(dut_cnt[k]), 0);
      check($sformatf("rst%0d_code", k), 32'(dut_code[k]), 0);
    end
    check("rst_flags", 32'({dut_act, dut_ent, dut_val, dut_rej}), 0);
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit cm, psel, ea, eb, da, db;
    bit [3:0] sw;
    bit ab, rdy;
    int cnt;
    int cd;
    bit ent, val, act;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit cm, psel, ea, eb, da, db, input int s, input bit ab, rdy,
                     input int cnt, cd, input bit ent, val, act);
    vec_t v;
    v.cm = cm; v.psel = psel; v.ea = ea; v.eb = eb; v.da = da; v.db = db;
    v.sw = 4'(s); v.ab = ab; v.rdy = rdy;
    v.cnt = cnt; v.cd = cd; v.ent = ent; v.val = val; v.act = act;
    tbl.push_back(v);
  endtask

  initial begin
    //  cm ps ea eb da db sw ab rdy | cnt  code  ent val act
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 'h000, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 5, 0, 0,   1, 'h005, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2, 0, 0,   2, 'h02A, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 7, 0, 0,   3, 'h157, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0,   4, 'hAB9, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,   4, 'hAB9, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 'h000, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 3, 0, 0,   0, 'h000, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 'h000, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 3, 0, 0,   1, 'h003, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 3, 0, 0,   2, 'h01B, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 3, 0, 0,   3, 'h0DB, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 3, 0, 0,   4, 'h6DB, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,   4, 'h6DB, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 'h000, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4, 0, 0,   1, 'h004, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 6, 0, 0,   2, 'h026, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 'h004, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 'h020, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0,   3, 'h101, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2, 0, 0,   4, 'h80A, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,   4, 'h80A, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 'h000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 'h000, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0,   1, 'h001, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2, 0, 0,   2, 'h00A, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 0, 0,   3, 'h053, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 'h000, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 'h000, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0,   1, 'h001, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0,   2, 'h009, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0,   3, 'h049, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0,   4, 'h249, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1,   4, 'h249, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 'h000, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 7, 0, 0,   1, 'h007, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 7, 0, 0,   2, 'h03F, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 7, 0, 0,   3, 'h1FF, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 7, 0, 0,   4, 'hFFF, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0,   4, 'hFFF, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 'h000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 'h000, 0, 0, 0);

    clear_inputs();
    model_reset();
    #2;
    check_model();
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      code_maker = tbl[i].cm; player_sel = tbl[i].psel;
      enter_a = tbl[i].ea; enter_b = tbl[i].eb; del_a = tbl[i].da; del_b = tbl[i].db;
      sw_w = tbl[i].sw; abort = tbl[i].ab; code_ready = tbl[i].rdy;
      step();
      check($sformatf("vec%0d_count", i), 32'(cnt_a), 32'(tbl[i].cnt));
      check($sformatf("vec%0d_code", i), 32'(code_a), 32'(tbl[i].cd));
      check($sformatf("vec%0d_flags", i), 32'({ent_a, val_a, act_a}),
            32'({tbl[i].ent, tbl[i].val, tbl[i].act}));
      clear_inputs();
    end

    // Duplicate rejection and enter+delete collision on the ALLOW_DUP=0 variant.
    async_reset_pulse();
    code_maker = 1; step(); clear_inputs();
    enter_a = 1; sw_w = 2; step();
    sw_w = 5; step();
    sw_w = 2; step();
    check("dup_reject", 32'(rej_d), 1);
    check("dup_count", 32'(cnt_d), 2);
    clear_inputs(); step();
    check("dup_reject_drop", 32'(rej_d), 0);
    enter_a = 1; del_a = 1; sw_w = 4; step();
    check("collide_count", 32'(cnt_d), 1);
    check("collide_reject", 32'(rej_d), 0);
    clear_inputs();

    // Asynchronous reset mid-entry, then a full 6x4-bit code on the wide variant.
    async_reset_pulse();
    code_maker = 1; step(); clear_inputs();
    foreach (dig[0][i]) if (i < 6) begin
      enter_a = 1;
      sw_w = (i == 0) ? 4'h9 : (i == 1) ? 4'h3 : (i == 2) ? 4'hF :
             (i == 3) ? 4'h0 : (i == 4) ? 4'h6 : 4'hA;
      step();
    end
    clear_inputs();
    check("wide_code", 32'(code_w), 32'h0093F06A);
    check("wide_valid", 32'(val_w), 1);
    check("wide_count", 32'(cnt_w), 6);
    code_ready = 1; step(); clear_inputs();
    check("wide_retained", 32'(code_w), 32'h0093F06A);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      code_maker = ($urandom_range(0, 99) < 30);
      player_sel = 1'($urandom);
      enter_a    = ($urandom_range(0, 99) < 35);
      enter_b    = ($urandom_range(0, 99) < 35);
      del_a      = ($urandom_range(0, 99) < 8);
      del_b      = ($urandom_range(0, 99) < 8);
      abort      = ($urandom_range(0, 99) < 3);
      code_ready = ($urandom_range(0, 99) < 30);
      sw_w       = 4'($urandom);
      step();
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
